// File: rtl/clahe_pkg.sv
// Shared constants, FSM encoding and helpers for the CLAHE clip/CDF/LUT stage.
package clahe_pkg;

  localparam int unsigned HIST_BINS  = 256;
  localparam int unsigned BIN_W      = 16;
  localparam int unsigned EXCESS_W   = 24;
  localparam int unsigned CDF_W      = 24;
  localparam int unsigned LUT_W      = 8;
  localparam int unsigned SCALE_FRAC = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P1_RD,
    ST_P1_DRAIN,
    ST_CALC,
    ST_P2_RD,
    ST_P2_DRAIN,
    ST_DONE
  } state_t;

  // Portion of a bin count above the clip threshold.
  function automatic logic [BIN_W-1:0] clip_excess(input logic [BIN_W-1:0] h,
                                                   input logic [BIN_W-1:0] clip);
    return (h > clip) ? (h - clip) : '0;
  endfunction

endpackage

// File: rtl/clahe_hist_clip_cdf_if.sv
// Histogram RAM read/clear-write port and LUT write port of clahe_hist_clip_cdf.
interface clahe_hist_clip_cdf_if #(
  parameter int unsigned TILE_NUM_BITS = 6
);

  logic [TILE_NUM_BITS-1:0] ram_rd_tile_idx;
  logic [7:0]               ram_rd_addr;
  logic [15:0]              ram_rd_data;
  logic [TILE_NUM_BITS-1:0] ram_wr_tile_idx;
  logic [7:0]               ram_wr_addr;
  logic [15:0]              ram_wr_data;
  logic                     ram_wr_en;
  logic                     lut_wr_en;
  logic [TILE_NUM_BITS-1:0] lut_wr_tile_idx;
  logic [7:0]               lut_wr_addr;
  logic [7:0]               lut_wr_data;

  modport master (
    output ram_rd_tile_idx, ram_rd_addr,
    input  ram_rd_data,
    output ram_wr_tile_idx, ram_wr_addr, ram_wr_data, ram_wr_en,
    output lut_wr_en, lut_wr_tile_idx, lut_wr_addr, lut_wr_data
  );

  modport slave (
    input  ram_rd_tile_idx, ram_rd_addr,
    output ram_rd_data,
    input  ram_wr_tile_idx, ram_wr_addr, ram_wr_data, ram_wr_en,
    input  lut_wr_en, lut_wr_tile_idx, lut_wr_addr, lut_wr_data
  );

endinterface

// File: rtl/clahe_cdf_lut_calc.sv
// Second-pass datapath: clip + redistribute each bin, accumulate the CDF and
// scale it into a registered 8-bit LUT write.
module clahe_cdf_lut_calc
  import clahe_pkg::*;
#(
  parameter int unsigned TILE_NUM_BITS = 6
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_vld,
  input  logic [7:0]               in_bin,
  input  logic [BIN_W-1:0]         in_data,
  input  logic [BIN_W-1:0]         clip,
  input  logic [BIN_W-1:0]         share,
  input  logic [7:0]               rem,
  input  logic [15:0]              scale,
  input  logic [TILE_NUM_BITS-1:0] in_tile,
  output logic                     lut_wr_en,
  output logic [TILE_NUM_BITS-1:0] lut_wr_tile_idx,
  output logic [7:0]               lut_wr_addr,
  output logic [LUT_W-1:0]         lut_wr_data
);

  localparam int unsigned PROD_W = CDF_W + 16;

  logic [CDF_W-1:0]  cdf;
  logic [CDF_W-1:0]  cdf_next;
  logic [CDF_W:0]    cdf_sum;
  logic [BIN_W:0]    c;
  logic [BIN_W-1:0]  h_clipped;
  logic [PROD_W-1:0] prod;
  logic [LUT_W-1:0]  lut;

  always_comb begin
    h_clipped = (in_data < clip) ? in_data : clip;
    c         = (BIN_W+1)'(h_clipped) + (BIN_W+1)'(share) + (BIN_W+1)'(in_bin < rem);
    cdf_sum   = {1'b0, cdf} + (CDF_W+1)'(c);
    cdf_next  = cdf_sum[CDF_W] ? '1 : cdf_sum[CDF_W-1:0];
    prod      = PROD_W'(cdf_next) * PROD_W'(scale);
    // Anything above bit SCALE_FRAC+LUT_W-1 of the product means the scaled value exceeds 255.
    lut       = (prod[PROD_W-1:SCALE_FRAC+LUT_W] != '0) ? '1
                                                         : prod[SCALE_FRAC+LUT_W-1:SCALE_FRAC];
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cdf             <= '0;
      lut_wr_en       <= 1'b0;
      lut_wr_tile_idx <= '0;
      lut_wr_addr     <= '0;
      lut_wr_data     <= '0;
    end else begin
      lut_wr_en <= in_vld;
      if (clr) begin
        cdf <= '0;
      end else if (in_vld) begin
        cdf <= cdf_next;
      end
      if (in_vld) begin
        lut_wr_tile_idx <= in_tile;
        lut_wr_addr     <= in_bin;
        lut_wr_data     <= lut;
      end
    end
  end

endmodule

// File: rtl/clahe_hist_clip_cdf.sv
// CLAHE clip/redistribute/CDF stage: per tile, one pass sums the clip excess,
// a second pass builds the mapping LUT. Optional CLAHE_CLIP_CLEAR_EN zeroes the bank read-first.
module clahe_hist_clip_cdf
  import clahe_pkg::*;
#(
  parameter int unsigned TILE_NUM_BITS = 6,
  parameter int unsigned RD_LAT        = 1
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  frame_hist_done,
  input  logic [15:0]           clip_limit,
  input  logic [15:0]           cdf_scale,
  clahe_hist_clip_cdf_if.master bus,
  output logic                  busy,
  output logic                  cdf_done,
  output logic                  overrun
);

  state_t                   state;
  logic [BIN_W-1:0]         clip_q;
  logic [15:0]              scale_q;
  logic [TILE_NUM_BITS-1:0] tile;
  logic [7:0]               addr;
  logic [1:0]               drain;
  logic [EXCESS_W-1:0]      excess;
  logic [BIN_W-1:0]         share;
  logic [7:0]               rem;
  logic                     cdf_clr;

  // Read-tracking pipelines: stage RD_LAT-1 lines up with ram_rd_data.
  logic [RD_LAT-1:0]        p1_pipe;
  logic [RD_LAT-1:0]        p2_pipe;
  logic [7:0]               bin_pipe [RD_LAT];

  assign bus.ram_rd_tile_idx = tile;
  assign bus.ram_rd_addr     = addr;
  assign cdf_clr             = (state == ST_CALC);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      clip_q   <= '0;
      scale_q  <= '0;
      tile     <= '0;
      addr     <= '0;
      drain    <= '0;
      excess   <= '0;
      share    <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      cdf_done <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      cdf_done <= 1'b0;
      overrun  <= frame_hist_done && (state != ST_IDLE);
      if (p1_pipe[RD_LAT-1]) begin
        excess <= excess + EXCESS_W'(clip_excess(bus.ram_rd_data, clip_q));
      end
      case (state)
        ST_IDLE: begin
          if (frame_hist_done) begin
            clip_q  <= clip_limit;
            scale_q <= cdf_scale;
            tile    <= '0;
            addr    <= '0;
            excess  <= '0;
            busy    <= 1'b1;
            state   <= ST_P1_RD;
          end
        end
        ST_P1_RD: begin
          addr <= addr + 8'd1;
          if (addr == 8'(HIST_BINS - 1)) begin
            drain <= '0;
            state <= ST_P1_DRAIN;
          end
        end
        ST_P1_DRAIN: begin
          drain <= drain + 2'd1;
          if (drain == 2'(RD_LAT - 1)) begin
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          share  <= excess[EXCESS_W-1:8];
          rem    <= excess[7:0];
          excess <= '0;
          state  <= ST_P2_RD;
        end
        ST_P2_RD: begin
          addr <= addr + 8'd1;
          if (addr == 8'(HIST_BINS - 1)) begin
            drain <= '0;
            state <= ST_P2_DRAIN;
          end
        end
        ST_P2_DRAIN: begin
          drain <= drain + 2'd1;
          // One extra cycle beyond RD_LAT lets the registered LUT write of bin 255 land.
          if (drain == 2'(RD_LAT)) begin
            tile <= tile + 1'b1;
            if (tile == '1) begin
              busy     <= 1'b0;
              cdf_done <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state <= ST_P1_RD;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      p1_pipe <= '0;
      p2_pipe <= '0;
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        bin_pipe[k] <= '0;
      end
    end else begin
      p1_pipe[0]  <= (state == ST_P1_RD);
      p2_pipe[0]  <= (state == ST_P2_RD);
      bin_pipe[0] <= addr;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        p1_pipe[k]  <= p1_pipe[k-1];
        p2_pipe[k]  <= p2_pipe[k-1];
        bin_pipe[k] <= bin_pipe[k-1];
      end
    end
  end

  clahe_cdf_lut_calc #(
    .TILE_NUM_BITS (TILE_NUM_BITS)
  ) u_calc (
    .pclk            (pclk),
    .rst_n           (rst_n),
    .clr             (cdf_clr),
    .in_vld          (p2_pipe[RD_LAT-1]),
    .in_bin          (bin_pipe[RD_LAT-1]),
    .in_data         (bus.ram_rd_data),
    .clip            (clip_q),
    .share           (share),
    .rem             (rem),
    .scale           (scale_q),
    .in_tile         (tile),
    .lut_wr_en       (bus.lut_wr_en),
    .lut_wr_tile_idx (bus.lut_wr_tile_idx),
    .lut_wr_addr     (bus.lut_wr_addr),
    .lut_wr_data     (bus.lut_wr_data)
  );

`ifdef CLAHE_CLIP_CLEAR_EN
  // The clear write trails the read by RD_LAT cycles, so each bin is consumed before it is zeroed.
  assign bus.ram_wr_en       = p2_pipe[RD_LAT-1];
  assign bus.ram_wr_addr     = bin_pipe[RD_LAT-1];
  assign bus.ram_wr_tile_idx = tile;
  assign bus.ram_wr_data     = '0;
`else
  assign bus.ram_wr_en       = 1'b0;
  assign bus.ram_wr_addr     = '0;
  assign bus.ram_wr_tile_idx = '0;
  assign bus.ram_wr_data     = '0;
`endif

endmodule
